// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, valid/ready on
// both the operand side and the result side, one operation in flight at a time.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             valid_src,
    output logic             src_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             dst_valid,
    input  logic             dst_ready
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    // The partial remainder never reaches 2^WIDTH between steps, so only the
    // trial difference needs the extra sign bit.
    logic [WIDTH-1:0]   r_r;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dbz;
    logic [WIDTH:0]     w_rshift;
    logic [WIDTH:0]     w_trial;
    logic               w_accept;
    logic               w_last;

    assign w_accept = (r_state == IDLE) && valid_src;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_rshift = {r_r, r_q[WIDTH-1]};
    assign w_trial  = w_rshift - {1'b0, r_d};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (valid_src) w_next = BUSY;
            BUSY:    if (w_last)    w_next = DONE;
            DONE:    if (dst_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        src_ready = 1'b0;
        dst_valid = 1'b0;
        case (r_state)
            IDLE:    src_ready = 1'b1;
            DONE:    dst_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load on accept, one restoring step per BUSY cycle, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q   <= '0;
            r_d   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= '0;
            r_dbz <= (divisor == '0);
        end else if (r_state == BUSY) begin
            if (!w_trial[WIDTH]) begin
                r_r <= w_trial[WIDTH-1:0];
            end else begin
                r_r <= w_rshift[WIDTH-1:0];
            end
            r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_r;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus a randomized sweep, checked by a
// scoreboard queue fed at each accept and drained by an independent monitor.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         valid_src = 1'b0;
    logic         src_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         dst_valid;
    logic         dst_ready = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    bit   rand_done = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .dividend   (dividend),
        .divisor    (divisor),
        .valid_src  (valid_src),
        .src_ready  (src_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Reference: integer division, with divide-by-zero giving all ones / dividend.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every consumed result against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (src_ready && dst_valid) begin
                total++;
                bad++;
                $display("FAIL exclusive: src_ready and dst_valid both 1");
            end
            if (dst_valid && dst_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: q=%0h r=%0h with empty scoreboard", quotient, remainder);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (quotient !== mon_e.q || remainder !== mon_e.r || div_by_zero !== mon_e.z) begin
                        bad++;
                        $display("FAIL result %0h/%0h: got q=%0h r=%0h z=%0b, expected q=%0h r=%0h z=%0b",
                                 mon_e.a, mon_e.b, quotient, remainder, div_by_zero,
                                 mon_e.q, mon_e.r, mon_e.z);
                    end
                    if (mon_e.b != '0) begin
                        total++;
                        if (32'(quotient) * 32'(mon_e.b) + 32'(remainder) != 32'(mon_e.a)
                            || remainder >= mon_e.b) begin
                            bad++;
                            $display("FAIL identity %0h/%0h: got q=%0h r=%0h", mon_e.a, mon_e.b,
                                     quotient, remainder);
                        end
                    end
                end
            end
        end
    end

    // Present an operand pair, wait for acceptance, push the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int  n = 0;
        bit  ok = 1'b0;
        dividend  = a;
        divisor   = b;
        valid_src = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            if (src_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: src_ready=%0b, expected 1 within 200 cycles", src_ready);
            valid_src = 1'b0;
        end else begin
            exp_q.push_back(model(a, b));
            @(posedge clk);
            #1;
            if (!hold) valid_src = 1'b0;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!dst_valid && n < 60);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_src_ready"}, src_ready, 1);
        chk({tag, "_dst_valid"}, dst_valid, 0);
        chk({tag, "_quotient"}, quotient, 0);
        chk({tag, "_remainder"}, remainder, 0);
        chk({tag, "_div_by_zero"}, div_by_zero, 0);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] a;
        logic [W-1:0] b;

        #2 reset = 1'b0;
        #10;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset     = 1'b1;
        dst_ready = 1'b1;

        // 100 / 7 with latency and return-to-idle timing
        issue(16'd100, 16'd7, 1'b0);
        wait_valid(lat);
        chk("lat_100_7", lat, 16);
        chk("q_100_7", quotient, 14);
        chk("r_100_7", remainder, 2);
        @(posedge clk);
        #1;
        chk("idle_src_ready", src_ready, 1);
        chk("idle_dst_valid", dst_valid, 0);
        chk("hold_q_after_done", quotient, 14);

        // back-to-back with valid_src held high
        issue(16'hFFFF, 16'h0001, 1'b1);
        issue(16'd3, 16'd10, 1'b1);
        issue(16'h8000, 16'hFFFF, 1'b0);
        wait_drain();

        // divide by zero
        issue(16'd5, 16'd0, 1'b0);
        wait_valid(lat);
        chk("lat_div0", lat, 16);
        chk("q_div0", quotient, 16'hFFFF);
        chk("r_div0", remainder, 5);
        chk("z_div0", div_by_zero, 1);
        wait_drain();

        // backpressure on 1000 / 33 while operands and valid_src wiggle
        dst_ready = 1'b0;
        issue(16'd1000, 16'd33, 1'b0);
        wait_valid(lat);
        chk("lat_bp", lat, 16);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            dividend  = W'($urandom);
            divisor   = W'($urandom);
            valid_src = ~valid_src;
            @(negedge clk);
            chk("bp_q", quotient, 30);
            chk("bp_r", remainder, 10);
            chk("bp_valid", dst_valid, 1);
            chk("bp_src_ready", src_ready, 0);
        end
        @(posedge clk);
        #1;
        valid_src = 1'b0;
        dst_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", dst_valid, 0);
        chk("bp_release_src_ready", src_ready, 1);
        chk("bp_queue_empty", exp_q.size(), 0);

        // asynchronous reset in the middle of 500 / 3
        issue(16'd500, 16'd3, 1'b0);
        repeat (8) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        issue(16'd500, 16'd3, 1'b0);
        wait_valid(lat);
        chk("lat_500_3", lat, 16);
        chk("q_500_3", quotient, 166);
        chk("r_500_3", remainder, 2);
        wait_drain();

        // randomized sweep with source gaps and destination stalls
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    a = W'($urandom);
                    case ($urandom_range(0, 7))
                        0: b = '0;
                        1: b = W'($urandom_range(1, 15));
                        2: begin
                            a = W'($urandom_range(0, 100));
                            b = W'($urandom_range(101, 65535));
                        end
                        default: b = W'($urandom);
                    endcase
                    issue(a, b, 1'b0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    dst_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        dst_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
